console_char_sender: RTL

//  CPU-side transmitter for the character display path. Accepts characters the CPU writes to the

---
 rtl/console_char_sender_pkg.sv | 14 +
 rtl/console_char_sender_if.sv | 23 ++
 rtl/console_char_sender_fifo.sv | 62 ++++++
 rtl/console_char_sender.sv | 124 ++++++++++++
 4 files changed

// File: rtl/console_char_sender_pkg.sv
// Shared types and constants for the console character sender.
package console_char_sender_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ADVANCE,
    GAP,
    PAD
  } state_t;

  localparam logic [3:0] NL_CODE_DEFAULT = 4'hF;

endpackage

// File: rtl/console_char_sender_if.sv
// CPU data-register side and character-processor side of the console sender.
interface console_char_sender_if #(
  parameter int CHAR_W = 4
);
  logic [CHAR_W-1:0] ddr_wdata;
  logic              ddr_we;
  logic              dsr_ready;
  logic              overflow;
  logic              busy;
  logic [CHAR_W-1:0] new_char;
  logic              text_en;
  logic              btn_pressed;

  modport master (
    output ddr_wdata, ddr_we,
    input  dsr_ready, overflow, busy, new_char, text_en, btn_pressed
  );

  modport slave (
    input  ddr_wdata, ddr_we,
    output dsr_ready, overflow, busy, new_char, text_en, btn_pressed
  );
endinterface

// File: rtl/console_char_sender_fifo.sv
// Synchronous character FIFO with a registered occupancy count; writes to a full
// FIFO and reads from an empty one are ignored.
module console_char_sender_fifo #(
  parameter int CHAR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CHAR_W-1:0] wdata_i,
  output logic [CHAR_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  // Flags come from the count at the start of the cycle, so a same-cycle pop
  // never makes room for a write to a full FIFO.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/console_char_sender.sv
// Replays CPU-written characters to the character processor as a text write
// followed by a cursor advance; newline codes pad the cursor to end of line.
module console_char_sender
  import console_char_sender_pkg::*;
#(
  parameter int                CHAR_W     = 4,
  parameter int                FIFO_DEPTH = 16,
  parameter int                COLS       = 80,
  parameter int                GAP_CYCLES = 2,
  parameter logic [CHAR_W-1:0] NL_CODE    = CHAR_W'(NL_CODE_DEFAULT)
) (
  input logic                  clk,
  input logic                  rst_n,
  console_char_sender_if.slave bus
);
  localparam int CLW = $clog2(COLS);
  localparam int PW  = $clog2(COLS + 1);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  state_t            state_q, state_d;
  logic [CLW-1:0]    col_q, col_d;
  logic [PW-1:0]     pad_q, pad_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [CHAR_W-1:0] new_char_q, new_char_d;
  logic              text_en_q, text_en_d;
  logic              btn_q, btn_d;
  logic              overflow_q, overflow_d;

  logic              fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CHAR_W-1:0] fifo_rdata;

  function automatic logic [CLW-1:0] next_col(input logic [CLW-1:0] c);
    return (c == CLW'(COLS - 1)) ? '0 : c + CLW'(1);
  endfunction

  console_char_sender_fifo #(
    .CHAR_W (CHAR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.ddr_we),
    .pop_i   (fifo_pop),
    .wdata_i (bus.ddr_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    pad_d      = pad_q;
    gap_d      = gap_q;
    new_char_d = new_char_q;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_rdata == NL_CODE) begin
            // Pad from the current column to the end of the line; at col 0 a full blank line.
            pad_d   = PW'(COLS) - PW'(col_q);
            state_d = PAD;
          end else begin
            new_char_d = fifo_rdata;
            state_d    = WRITE;
          end
        end
      end
      WRITE:   state_d = ADVANCE;
      ADVANCE: begin
        col_d   = next_col(col_q);
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = (pad_q != '0) ? PAD : IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      PAD: begin
        pad_d   = pad_q - PW'(1);
        state_d = ADVANCE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    text_en_d  = (state_d == WRITE);
    btn_d      = (state_d == ADVANCE);
    overflow_d = overflow_q || (bus.ddr_we && fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      pad_q      <= '0;
      gap_q      <= '0;
      new_char_q <= '0;
      text_en_q  <= 1'b0;
      btn_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      pad_q      <= pad_d;
      gap_q      <= gap_d;
      new_char_q <= new_char_d;
      text_en_q  <= text_en_d;
      btn_q      <= btn_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.new_char    = new_char_q;
  assign bus.text_en     = text_en_q;
  assign bus.btn_pressed = btn_q;
  assign bus.overflow    = overflow_q;
  assign bus.dsr_ready   = !fifo_full;
  assign bus.busy        = !fifo_empty || (state_q != IDLE);

endmodule
